fpadd_pipe: RTL and testbench

Parametrised, pipelined IEEE-754-style floating-point adder/subtractor, next generation of the combinational half-precision `FPADD` in the ALU. It takes `opA_i` and `opB_i` plus an operation select through a valid/ready handshake and returns the rounded sum or difference three cycles later with exception flags and a pass-through tag. It sits between the ALU operand-issue logic and the writeback arbiter.

---
 rtl/fpadd_pkg.sv | 37 +++
 rtl/fpadd_lzc.sv | 17 +
 rtl/fpadd_pipe.sv | 241 ++++++++++++++++++++++++
 tb/tb_fpadd_pipe.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/fpadd_pkg.sv
// Shared types and helpers for the pipelined floating-point adder.
package fpadd_pkg;

  localparam int FLG_INV = 2;
  localparam int FLG_OVF = 1;
  localparam int FLG_UNF = 0;

  // Unpacked fields are sized for the widest format; users slice them.
  localparam int EXP_W_MAX = 16;
  localparam int MAN_W_MAX = 63;
  localparam int WORD_MAX  = 1 + EXP_W_MAX + MAN_W_MAX;

  typedef struct packed {
    logic                 sign;
    logic [EXP_W_MAX-1:0] exp;
    logic [MAN_W_MAX:0]   man;
    logic                 is_nan;
    logic                 is_inf;
    logic                 is_zero;
  } fp_unpk_t;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic logic [WORD_MAX-1:0] canon_nan(
    input int exp_w,
    input int man_w
  );
    logic [WORD_MAX-1:0] r;
    r = '0;
    for (int i = 0; i < exp_w; i++) r[man_w + i] = 1'b1;
    r[man_w - 1] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/fpadd_lzc.sv
// Parametrised leading-zero counter; an all-zero input returns W.
module fpadd_lzc #(
  parameter  int W  = 14,
  localparam int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  val,
  output logic [CW-1:0] cnt
);

  always_comb begin
    cnt = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (val[i]) cnt = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/fpadd_pipe.sv
// Three-stage floating-point add/sub with valid/ready handshake.
// Define FPADD_PIPE_RNE_EN for round-to-nearest-even, else truncation.
module fpadd_pipe #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int TAG_W = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [EXP_W+MAN_W:0] opA_i,
  input  logic [EXP_W+MAN_W:0] opB_i,
  input  logic                 sub_i,
  input  logic [TAG_W-1:0]     tag_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [EXP_W+MAN_W:0] ADD_o,
  output logic [2:0]           flags_o,
  output logic [TAG_W-1:0]     tag_o
);

  import fpadd_pkg::*;

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int M  = MAN_W + 1;
  localparam int XW = MAN_W + 4;
  localparam int EW = EXP_W + 1;
  localparam int CW = $clog2(XW + 1);
  localparam int SW = (EW > CW) ? EW : CW;

  localparam logic [EW-1:0] EXP_ONES = EW'(2 * fp_bias(EXP_W) + 1);
  localparam logic [W-2:0]  INF_MAG  = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};
  localparam logic [W-1:0]  QNAN     = W'(canon_nan(EXP_W, MAN_W));

  function automatic fp_unpk_t fp_unpack(input logic [W-1:0] x);
    fp_unpk_t         u;
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] f;
    e = x[W-2:MAN_W];
    f = x[MAN_W-1:0];
    u = '0;
    u.sign = x[W-1];
    u.exp[EXP_W-1:0] = (e == '0) ? EXP_W'(1) : e;
    u.man[MAN_W:0] = {|e, f};
    u.is_nan = (&e) & (|f);
    u.is_inf = (&e) & ~(|f);
    u.is_zero = ~(|e) & ~(|f);
    return u;
  endfunction

  logic adv;

  assign adv = !out_valid_o || out_ready_i;
  assign in_ready_o = adv;

  // S1: unpack, order by magnitude, align
  fp_unpk_t             ua;
  fp_unpk_t             ub;
  logic                 swap;
  logic                 lost;
  logic [EXP_W_MAX-1:0] diff;
  logic [XW-1:0]        mb_raw;
  logic [XW-1:0]        c1_ma;
  logic [XW-1:0]        c1_mb;
  logic [EXP_W-1:0]     c1_exp;
  logic                 c1_sign;
  logic                 c1_esub;
  logic                 c1_nz;
  logic                 c1_nan;
  logic                 c1_byp;
  logic [W-1:0]         c1_res;

  always_comb begin
    ua = fp_unpack(opA_i);
    ub = fp_unpack(opB_i);
    ub.sign = ub.sign ^ sub_i;
    swap = {ub.exp, ub.man} > {ua.exp, ua.man};
    diff = swap ? ub.exp - ua.exp : ua.exp - ub.exp;
    c1_ma = {swap ? ub.man[MAN_W:0] : ua.man[MAN_W:0], 3'b000};
    mb_raw = {swap ? ua.man[MAN_W:0] : ub.man[MAN_W:0], 3'b000};
    lost = 1'b0;
    for (int i = 0; i < XW; i++) begin
      if (EXP_W_MAX'(i) < diff) lost = lost | mb_raw[i];
    end
    if (diff >= EXP_W_MAX'(XW - 1))
      c1_mb = {{(XW-1){1'b0}}, |mb_raw};
    else
      c1_mb = (mb_raw >> diff) | {{(XW-1){1'b0}}, lost};
    c1_exp = swap ? ub.exp[EXP_W-1:0] : ua.exp[EXP_W-1:0];
    c1_sign = swap ? ub.sign : ua.sign;
    c1_esub = ua.sign ^ ub.sign;
    c1_nz = ua.is_zero & ub.is_zero & ua.sign & ub.sign;
    c1_nan = ua.is_nan | ub.is_nan
           | (ua.is_inf & ub.is_inf & c1_esub);
    c1_byp = c1_nan | ua.is_inf | ub.is_inf;
    if (c1_nan)         c1_res = QNAN;
    else if (ua.is_inf) c1_res = {ua.sign, INF_MAG};
    else                c1_res = {ub.sign, INF_MAG};
  end

  logic             s1_v;
  logic [TAG_W-1:0] s1_tag;
  logic [XW-1:0]    s1_ma;
  logic [XW-1:0]    s1_mb;
  logic [EXP_W-1:0] s1_exp;
  logic             s1_sign;
  logic             s1_esub;
  logic             s1_nz;
  logic             s1_inv;
  logic             s1_byp;
  logic [W-1:0]     s1_res;

  // S2: effective add or subtract; s1_ma >= s1_mb by construction
  logic [XW:0] c2_sum;

  always_comb begin
    if (s1_esub) c2_sum = {1'b0, s1_ma} - {1'b0, s1_mb};
    else         c2_sum = {1'b0, s1_ma} + {1'b0, s1_mb};
  end

  logic             s2_v;
  logic [TAG_W-1:0] s2_tag;
  logic [XW:0]      s2_sum;
  logic [EXP_W-1:0] s2_exp;
  logic             s2_sign;
  logic             s2_nz;
  logic             s2_inv;
  logic             s2_byp;
  logic [W-1:0]     s2_res;

  // S3: normalise, round, pack
  logic [CW-1:0]    lz;
  logic [EW-1:0]    lim;
  logic [SW-1:0]    sh;
  logic [XW-1:0]    m;
  logic [EW-1:0]    en;
  logic [EW-1:0]    en2;
  logic             inc;
  logic [M:0]       rm;
  logic             hid;
  logic [MAN_W-1:0] frac;
  logic [EXP_W-1:0] fld;
  logic             ovf;
  logic             nonzero;
  logic [W-1:0]     c3_res;
  logic [2:0]       c3_flg;

  fpadd_lzc #(.W(XW)) u_lzc (
    .val (s2_sum[XW-1:0]),
    .cnt (lz)
  );

  always_comb begin
    lim = {1'b0, s2_exp} - EW'(1);
    sh = '0;
    if (s2_sum[XW]) begin
      m = {s2_sum[XW:2], s2_sum[1] | s2_sum[0]};
      en = {1'b0, s2_exp} + EW'(1);
    end else begin
      sh = (SW'(lz) > SW'(lim)) ? SW'(lim) : SW'(lz);
      m = s2_sum[XW-1:0] << sh;
      en = {1'b0, s2_exp} - EW'(sh);
    end
`ifdef FPADD_PIPE_RNE_EN
    inc = m[2] & (m[1] | m[0] | m[3]);
`else
    inc = 1'b0;
`endif
    rm = {1'b0, m[XW-1:3]} + {{M{1'b0}}, inc};
    if (rm[M]) begin
      hid = 1'b1;
      frac = rm[MAN_W:1];
      en2 = en + EW'(1);
    end else begin
      hid = rm[MAN_W];
      frac = rm[MAN_W-1:0];
      en2 = en;
    end
    fld = hid ? en2[EXP_W-1:0] : '0;
    ovf = hid & (en2 >= EXP_ONES);
    nonzero = |m;
    c3_res = {s2_sign, fld, frac};
    c3_flg = '0;
    if (s2_byp) begin
      c3_res = s2_res;
      c3_flg[FLG_INV] = s2_inv;
    end else if (!nonzero) begin
      c3_res = {s2_nz, {(W-1){1'b0}}};
    end else if (ovf) begin
      c3_res = {s2_sign, INF_MAG};
      c3_flg[FLG_OVF] = 1'b1;
    end else begin
      c3_flg[FLG_UNF] = !hid;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      out_valid_o <= 1'b0;
      ADD_o <= '0;
      flags_o <= '0;
      tag_o <= '0;
    end else if (adv) begin
      s1_v <= in_valid_i;
      s2_v <= s1_v;
      out_valid_o <= s2_v;
      if (s2_v) begin
        ADD_o <= c3_res;
        flags_o <= c3_flg;
        tag_o <= s2_tag;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (adv) begin
      s1_tag <= tag_i;
      s1_ma <= c1_ma;
      s1_mb <= c1_mb;
      s1_exp <= c1_exp;
      s1_sign <= c1_sign;
      s1_esub <= c1_esub;
      s1_nz <= c1_nz;
      s1_inv <= c1_nan;
      s1_byp <= c1_byp;
      s1_res <= c1_res;
      s2_tag <= s1_tag;
      s2_sum <= c2_sum;
      s2_exp <= s1_exp;
      s2_sign <= s1_sign;
      s2_nz <= s1_nz;
      s2_inv <= s1_inv;
      s2_byp <= s1_byp;
      s2_res <= s1_res;
    end
  end

endmodule

// File: tb/tb_fpadd_pipe.sv
// Scoreboard bench for fpadd_pipe with half-precision directed vectors.
module tb_fpadd_pipe;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [15:0] opA_i = '0;
  logic [15:0] opB_i = '0;
  logic        sub_i = 1'b0;
  logic [3:0]  tag_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b1;
  logic [15:0] ADD_o;
  logic [2:0]  flags_o;
  logic [3:0]  tag_o;

  fpadd_pipe dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .opA_i       (opA_i),
    .opB_i       (opB_i),
    .sub_i       (sub_i),
    .tag_i       (tag_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .ADD_o       (ADD_o),
    .flags_o     (flags_o),
    .tag_o       (tag_o)
  );

  always #5 clk_i = ~clk_i;

  localparam int NV = 16;

  logic [15:0] va [NV];
  logic [15:0] vb [NV];
  logic        vs [NV];
  logic [15:0] vr [NV];
  logic [2:0]  vf [NV];

  logic [22:0] sb [$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, want);
    end
  endtask

  task automatic setv(input int i, input logic [15:0] a, input logic [15:0] b,
                      input logic s, input logic [15:0] r, input logic [2:0] f);
    va[i] = a;
    vb[i] = b;
    vs[i] = s;
    vr[i] = r;
    vf[i] = f;
  endtask

  task automatic issue(input int i, input logic [3:0] t);
    int   n;
    logic acc;
    n = 0;
    acc = 1'b0;
    opA_i = va[i];
    opB_i = vb[i];
    sub_i = vs[i];
    tag_i = t;
    in_valid_i = 1'b1;
    while (!acc && n < 100) begin
      @(negedge clk_i);
      acc = in_ready_o;
      if (acc) sb.push_back({t, vf[i], vr[i]});
      @(posedge clk_i);
      #1;
      n++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: tag %h never accepted", t);
    end
  endtask

  // Monitor: pops on handshake, checks held value while stalled
  initial begin
    forever begin
      @(negedge clk_i);
      if (!rst_i && out_valid_o) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got tag %h res %h expected none",
                   tag_o, ADD_o);
        end else begin
          chk(out_ready_i ? "result" : "stall_hold",
              {9'b0, tag_o, flags_o, ADD_o}, {9'b0, sb[0]});
          if (out_ready_i) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    int lat;
    int n;
    setv(0,  16'h3E00, 16'h3C00, 1'b0, 16'h4100, 3'b000);
    setv(1,  16'h4100, 16'h3E00, 1'b1, 16'h3C00, 3'b000);
    setv(2,  16'h0001, 16'h0001, 1'b0, 16'h0002, 3'b001);
    setv(3,  16'h0002, 16'h8002, 1'b0, 16'h0000, 3'b000);
    setv(4,  16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 3'b010);
    setv(5,  16'h0400, 16'h8001, 1'b0, 16'h03FF, 3'b001);
    setv(6,  16'h7C00, 16'hFC00, 1'b0, 16'h7E00, 3'b100);
`ifdef FPADD_PIPE_RNE_EN
    setv(7,  16'h6801, 16'h3C00, 1'b0, 16'h6802, 3'b000);
    setv(15, 16'h6800, 16'h3E00, 1'b0, 16'h6801, 3'b000);
`else
    setv(7,  16'h6801, 16'h3C00, 1'b0, 16'h6801, 3'b000);
    setv(15, 16'h6800, 16'h3E00, 1'b0, 16'h6800, 3'b000);
`endif
    setv(8,  16'h8000, 16'h8000, 1'b0, 16'h8000, 3'b000);
    setv(9,  16'h3C00, 16'h3C00, 1'b1, 16'h0000, 3'b000);
    setv(10, 16'h7C00, 16'h3C00, 1'b0, 16'h7C00, 3'b000);
    setv(11, 16'h3C00, 16'h7C00, 1'b1, 16'hFC00, 3'b000);
    setv(12, 16'h7C01, 16'h0000, 1'b0, 16'h7E00, 3'b100);
    setv(13, 16'hC000, 16'h3C00, 1'b0, 16'hBC00, 3'b000);
    setv(14, 16'h3C00, 16'h0001, 1'b0, 16'h3C00, 3'b000);

    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    chk("rst_valid", {31'b0, out_valid_o}, 32'd0);
    chk("rst_add", {16'b0, ADD_o}, 32'd0);
    chk("rst_flags", {29'b0, flags_o}, 32'd0);
    chk("rst_tag", {28'b0, tag_o}, 32'd0);
    chk("rst_ready", {31'b0, in_ready_o}, 32'd1);

    issue(0, 4'hA);
    in_valid_i = 1'b0;
    lat = 1;
    while (!out_valid_o && lat < 20) begin
      @(posedge clk_i);
      #1;
      lat++;
    end
    chk("latency", lat, 32'd3);
    repeat (3) @(posedge clk_i);
    #1;

    fork
      begin
        for (int i = 0; i < NV; i++) issue(i, 4'(i));
        in_valid_i = 1'b0;
      end
      begin
        repeat (6) @(posedge clk_i);
        #1;
        out_ready_i = 1'b0;
        @(negedge clk_i);
        chk("in_ready_stall", {31'b0, in_ready_o}, 32'd0);
        repeat (3) @(posedge clk_i);
        #1;
        out_ready_i = 1'b1;
      end
    join

    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    chk("drained", sb.size(), 32'd0);

    issue(1, 4'h5);
    issue(2, 4'h6);
    in_valid_i = 1'b0;
    rst_i = 1'b1;
    sb.delete();
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    chk("rst_flush_valid", {31'b0, out_valid_o}, 32'd0);
    repeat (6) begin
      @(negedge clk_i);
      chk("rst_no_emerge", {31'b0, out_valid_o}, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
